// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with registered sync/de/coords
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 80,
  parameter int H_BP     = 104,
  parameter int V_ACTIVE = 450,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 15,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input  logic          clk_vga,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    scale,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_END  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_END  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_DE_START  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] V_DE_START  = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] H_DE_END    = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_DE_END    = CW'(V_SYNC + V_BP + V_ACTIVE);

  generate
    if ((H_TOTAL > (2 ** CW) - 1) || (V_TOTAL > (2 ** CW) - 1)) begin : g_param_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end
  endgenerate

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;

  logic          hs_i;
  logic          vs_i;
  logic          de_i;
  logic [CW-1:0] x_off;
  logic [CW-1:0] y_off;
  logic [CW-1:0] x_next;
  logic [CW-1:0] y_next;

  always_comb begin
    hs_i   = (hc < H_SYNC_END);
    vs_i   = (vc < V_SYNC_END);
    de_i   = (hc >= H_DE_START) && (hc < H_DE_END) &&
             (vc >= V_DE_START) && (vc < V_DE_END);
    x_off  = hc - H_DE_START;
    y_off  = vc - V_DE_START;
    x_next = de_i ? (x_off >> scale) : '0;
    y_next = de_i ? (y_off >> scale) : '0;
  end

  // Raster counters: hc wraps at H_TOTAL-1 with no extra count; vc steps on that wrap.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (en) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Outputs advance in lockstep with the counters; strobes drop on idle cycles.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (en) begin
        hs          <= hs_i ? HS_POL : ~HS_POL;
        vs          <= vs_i ? VS_POL : ~VS_POL;
        de          <= de_i;
        x           <= x_next;
        y           <= y_next;
        line_start  <= (hc == '0);
        frame_start <= (hc == '0) && (vc == '0);
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator, successor to the fixed 800x450 driver. Timing is fully set by parameters, sync polarity is selectable, and a pixel-clock enable plus a runtime coordinate downscale mode are added. All outputs are registered, and it emits frame/line start strobes and a data-enable flag. It sits between the pixel clock domain (clk_vga) and the pixel generator/framebuffer reader, driving the board's HS/VS pins.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 80, horizontal sync width (pixels)
H_BP, 104, horizontal back porch (pixels)
V_ACTIVE, 450, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 5, vertical sync width (lines)
V_BP, 15, vertical back porch (lines)
HS_POL, 0, hs level during sync (0 = active-low)
VS_POL, 0, vs level during sync
CW, 11, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk_vga  in  1  pixel clock
rst  in  1  synchronous reset, active-high
en  in  1  pixel advance enable; counters step only when high
scale  in  2  coordinate downscale: 0 = /1, 1 = /2, 2 = /4, 3 = /8
hs  out  1  horizontal sync
vs  out  1  vertical sync
de  out  1  high inside the active area
x  out  CW  visible column (after scale); 0 outside active area
y  out  CW  visible row (after scale); 0 outside active area
line_start  out  1  one-cycle strobe at hc = 0
frame_start  out  1  one-cycle strobe at hc = 0 and vc = 0

Behaviour:
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (default 1008). V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (default 473).
- Region order per line and per frame: sync, back porch, active, front porch, starting at count 0.
- hc counts 0..H_TOTAL-1. On a cycle with en=1 it increments. At H_TOTAL-1 it wraps to 0. There is no extra count, which removes the predecessor's off-by-one.
- vc steps only when en=1 and hc = H_TOTAL-1. It wraps from V_TOTAL-1 to 0.
- Combinational decode from the current (hc, vc):
  - hs_i = (hc < H_SYNC)
  - vs_i = (vc < V_SYNC)
  - de_h = H_SYNC+H_BP <= hc < H_SYNC+H_BP+H_ACTIVE; de_v likewise on vc
  - de_i = de_h & de_v
- Output stage (all registered), updated on every cycle with en=1:
  - hs = hs_i ? HS_POL : ~HS_POL; vs uses VS_POL the same way
  - de = de_i
  - x = de_i ? (hc-(H_SYNC+H_BP)) >> scale : 0
  - y = de_i ? (vc-(V_SYNC+V_BP)) >> scale : 0
  - line_start = (hc = 0); frame_start = (hc = 0 & vc = 0)
- Latency: outputs reflect the counter value one clock earlier. Counter and outputs stay aligned because both advance only when en=1.
- en=0:
  - counters hold; hs, vs, de, x, y hold
  - line_start and frame_start are forced to 0, so each strobe is high for at most one clk_vga cycle per event
- scale is sampled every cycle. A change takes effect on the next registered x/y, and the counters are not disturbed.
- Reset (rst=1 at a clock edge, including mid-frame):
  - hc = 0, vc = 0
  - hs = ~HS_POL, vs = ~VS_POL (inactive), de = 0, x = 0, y = 0, line_start = 0, frame_start = 0
  - first enabled cycle after release: registers capture hc = 0, vc = 0, giving frame_start = 1, line_start = 1, hs and vs active
- rst has priority over en.
- Elaboration check: a parameter set whose totals exceed 2^CW-1 is an error (assertion).

Test Plan:
1. Reset then en=1 constantly, defaults -> cycle 1 after release: frame_start = 1, line_start = 1, hs = 0, vs = 0. hs returns high after 80 cycles. line_start period is 1008 cycles; frame_start period is 476784 cycles.
2. Active window, scale=0 -> de first rises at line vc = 20, hc = 184 with x = 0, y = 0. Last de cycle per line has x = 799. Last active line has y = 449. de count per frame is 360000.
3. scale=1, then scale=3 -> at hc = 983, vc = 469: x = 399, y = 224 (scale=1); x = 99, y = 56 (scale=3). x holds each value for 2 (respectively 8) consecutive de cycles.
4. en toggled 1/0 alternately -> line_start period is 2016 clk cycles and each strobe is exactly 1 cycle wide. x/y/de sequence is identical to the en=1 run.
5. HS_POL = 1, VS_POL = 1 instance -> hs high for exactly 80 enabled cycles per line. vs high for exactly 5 lines per frame. Both are low after reset.
6. rst pulsed at vc = 300, hc = 500 -> next cycle de = 0, x = 0, y = 0, hs and vs inactive. After release the sequence restarts exactly as in scenario 1.
